// File: rtl/edge_trigger_pkg.sv
// Shared defaults and helpers for the edge trigger array.
// Imported by the channel and the top level.
package edge_trigger_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FILTER_CYCLES = 4;
  localparam int DEF_COUNT_WIDTH   = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: sync chain, glitch filter, edge pulses,
// sticky pending flag and saturating edge counter.
module edge_channel
  import edge_trigger_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   i_raw,
  input  logic                   i_rise_en,
  input  logic                   i_fall_en,
  input  logic                   i_event_clr,
  input  logic                   i_count_clr,
  output logic                   o_active,
  output logic                   o_rise,
  output logic                   o_fall,
  output logic                   o_pending,
  output logic [COUNT_WIDTH-1:0] o_count
);

  localparam int CW = clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_f;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_pend;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_s;
  logic                   w_qe;
  logic                   w_sat;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Pulses are raised together with the filtered level update.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_f    <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_f    <= w_s;
        r_cnt  <= '0;
        r_rise <= w_s;
        r_fall <= ~w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_qe  = (r_rise & i_rise_en) | (r_fall & i_fall_en);
  assign w_sat = &r_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pend <= 1'b0;
    end else if (w_qe) begin
      r_pend <= 1'b1;
    end else if (i_event_clr) begin
      r_pend <= 1'b0;
    end
  end

  // A clear coinciding with an edge keeps that edge as count 1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (i_count_clr) begin
      r_count <= COUNT_WIDTH'(w_qe);
    end else if (w_qe && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_active  = r_f;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pending = r_pend;
  assign o_count   = r_count;

endmodule

// File: rtl/edge_trigger_array.sv
// Multi-channel edge detector with per-channel polarity,
// filtering, pending flags, counters and a combined IRQ.
module edge_trigger_array
  import edge_trigger_pkg::*;
#(
  parameter int                  CHANNELS      = 8,
  parameter int                  SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int                  FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW    = '0,
  parameter int                  COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [CHANNELS-1:0]             IN,
  input  logic [CHANNELS-1:0]             RISE_EN,
  input  logic [CHANNELS-1:0]             FALL_EN,
  input  logic [CHANNELS-1:0]             EVENT_CLEAR,
  input  logic [CHANNELS-1:0]             COUNT_CLEAR,
  output logic [CHANNELS-1:0]             ACTIVE,
  output logic [CHANNELS-1:0]             RISING_EDGE,
  output logic [CHANNELS-1:0]             FALLING_EDGE,
  output logic [CHANNELS-1:0]             EVENT_PENDING,
  output logic [CHANNELS*COUNT_WIDTH-1:0] EDGE_COUNT,
  output logic                            IRQ
);

  logic [CHANNELS-1:0] w_raw;

  // Polarity goes in front of the sync chain so reset means inactive.
  assign w_raw = IN ^ ACTIVE_LOW;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .COUNT_WIDTH   (COUNT_WIDTH)
    ) u_ch (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .i_raw       (w_raw[g]),
      .i_rise_en   (RISE_EN[g]),
      .i_fall_en   (FALL_EN[g]),
      .i_event_clr (EVENT_CLEAR[g]),
      .i_count_clr (COUNT_CLEAR[g]),
      .o_active    (ACTIVE[g]),
      .o_rise      (RISING_EDGE[g]),
      .o_fall      (FALLING_EDGE[g]),
      .o_pending   (EVENT_PENDING[g]),
      .o_count     (EDGE_COUNT[g*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

  assign IRQ = |EVENT_PENDING;

endmodule

// File: doc/edge_trigger_array.md
Name: edge_trigger_array

Overview:
- Multi-channel, parametrised edge detector that replaces single-signal edge triggering across the design.
- Per channel:
  - synchroniser for asynchronous pins (buttons, strobes, external handshakes);
  - per-channel polarity;
  - debounce/glitch filter;
  - registered one-cycle rising/falling pulses;
  - per-edge enables;
  - sticky event flags with clear;
  - saturating edge counters.
- A combined IRQ feeds the system controller.

Parameters:
- CHANNELS, 8, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 4, consecutive cycles a new level must hold before acceptance (>=1; 1 = no filtering beyond the sync chain).
- ACTIVE_LOW, {CHANNELS{1'b0}}, per-channel polarity mask; bit set = channel is active when its pin is low.
- COUNT_WIDTH, 8, width of each per-channel edge counter.

Ports:
- CLK  input  1  single system clock; all logic on posedge.
- RST_N  input  1  asynchronous active-low reset.
- IN  input  CHANNELS  raw, possibly asynchronous, pin levels.
- RISE_EN  input  CHANNELS  per channel; rising edges set pending and count.
- FALL_EN  input  CHANNELS  per channel; falling edges set pending and count.
- EVENT_CLEAR  input  CHANNELS  per-channel clear of EVENT_PENDING (level; one cycle suffices).
- COUNT_CLEAR  input  CHANNELS  per-channel clear of EDGE_COUNT.
- ACTIVE  output  CHANNELS  filtered, polarity-adjusted level.
- RISING_EDGE  output  CHANNELS  one-cycle pulse when ACTIVE goes 0->1 (independent of RISE_EN).
- FALLING_EDGE  output  CHANNELS  one-cycle pulse when ACTIVE goes 1->0 (independent of FALL_EN).
- EVENT_PENDING  output  CHANNELS  sticky flag; an enabled edge has occurred.
- EDGE_COUNT  output  CHANNELS*COUNT_WIDTH  flattened counters; channel c occupies bits [c*COUNT_WIDTH +: COUNT_WIDTH].
- IRQ  output  1  OR of all EVENT_PENDING bits (combinational from registers).

Behaviour:
- Reset (RST_N low, asynchronous): all state clears to 0.
  - State cleared: sync chains, filter counters, filtered level, pulse regs, pending flags, counters.
  - Resulting outputs: ACTIVE=0, RISING_EDGE=0, FALLING_EDGE=0, EVENT_PENDING=0, EDGE_COUNT=0, IRQ=0.
- Polarity: s_raw[c] = IN[c] ^ ACTIVE_LOW[c]. Polarity is applied before the sync chain, so the sync reset value 0 means "inactive" for every channel.
- Sync: SYNC_STAGES-deep shift chain per channel; s = last stage.
- Filter (per channel), using filtered level F and counter cnt (width clog2(FILTER_CYCLES)+1):
  - If s == F: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: F <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to F before acceptance restarts the count.
- ACTIVE = F.
- Edge pulses:
  - RISING_EDGE is registered and asserts in the same cycle ACTIVE first reads 1; high exactly one cycle.
  - FALLING_EDGE is the same for 1->0.
  - Rising and falling can never assert together on one channel.
- Latency: an IN change stable before posedge 0 appears on ACTIVE and the edge pulse after SYNC_STAGES+FILTER_CYCLES posedges. Defaults: 6 cycles.
- Qualified edge: qe = (RISING_EDGE & RISE_EN) | (FALLING_EDGE & FALL_EN). Enables are sampled in the pulse cycle; set/count updates land the following cycle.
- EVENT_PENDING:
  - Set by qe.
  - Cleared by EVENT_CLEAR.
  - Simultaneous qe and clear: set wins, so no event is lost.
- EDGE_COUNT:
  - qe increments the counter; it saturates at all-ones with no wrap.
  - COUNT_CLEAR resets it to 0.
  - Simultaneous clear and qe: result is 1.
- IRQ: asserted while any EVENT_PENDING bit is 1.
- Reset mid-operation:
  - Pending events and counts are lost.
  - A pin held active through reset release produces a fresh rising edge after full latency. This is intended.
  - Idle-high pins on ACTIVE_LOW channels produce no spurious edge.
- Channels are fully independent; no cross-channel arbitration.

Decomposition:
- Shared package edge_trigger_pkg:
  - default parameter constants (SYNC_STAGES, FILTER_CYCLES, COUNT_WIDTH);
  - a clog2 function for the filter counter width.
- Sub-module edge_channel: one channel (sync, filter, pulses, pending, counter).
- Top level: generate loop of CHANNELS instances plus the IRQ OR-reduce.

Test Plan:
- Reset then IN=0x00, ACTIVE_LOW=0 -> all outputs 0.
  - IN[0] 0->1 stable: ACTIVE[0] and RISING_EDGE[0] assert exactly 6 cycles later.
  - RISING_EDGE[0] is high 1 cycle only.
- Glitch: IN[1] high for 3 cycles then low (FILTER_CYCLES=4) -> ACTIVE[1] never rises, no pulse.
  - Same pin high 4+ cycles (counted at sync output) -> accepted.
- Enables: RISE_EN[2]=0, FALL_EN[2]=1; toggle pin 0->1->0.
  - Both pulses appear.
  - EVENT_PENDING[2] sets only after the fall.
  - EDGE_COUNT[2]=1; IRQ=1.
  - EVENT_CLEAR[2] pulse -> pending 0, IRQ 0.
- Collisions:
  - EVENT_CLEAR[3] asserted in the same cycle qe lands -> EVENT_PENDING[3] stays 1.
  - COUNT_CLEAR[3] with simultaneous qe -> EDGE_COUNT[3]=1.
- Saturation: COUNT_WIDTH=4, 20 enabled edges on channel 4 -> EDGE_COUNT[4]=15, no wrap.
- Polarity/reset: ACTIVE_LOW[5]=1, IN[5]=1 through reset release -> no pulse.
  - Assert RST_N low mid-count -> all outputs 0 immediately (async).
  - Release with IN[5]=0 held -> rising pulse after 6 cycles.
